// File: rtl/rocc_mem_responder.sv
// Fixed-latency RoCC memory responder: services load/store requests from a 64-bit
// scratchpad and returns tagged responses LATENCY cycles after accept, in order.
module rocc_mem_responder #(
  parameter int DEPTH        = 256,
  parameter int LATENCY      = 4,
  parameter int MAX_INFLIGHT = 2
) (
  input  logic        clk,
  input  logic        reset,

  output logic        io_mem_req_ready,
  input  logic        io_mem_req_valid,
  input  logic [39:0] io_mem_req_bits_addr,
  input  logic [9:0]  io_mem_req_bits_tag,
  input  logic [4:0]  io_mem_req_bits_cmd,
  input  logic [2:0]  io_mem_req_bits_typ,
  input  logic        io_mem_req_bits_phys,
  input  logic [63:0] io_mem_req_bits_data,
  input  logic        io_mem_invalidate_lr,

  output logic        io_mem_resp_valid,
  output logic [39:0] io_mem_resp_bits_addr,
  output logic [9:0]  io_mem_resp_bits_tag,
  output logic [4:0]  io_mem_resp_bits_cmd,
  output logic [2:0]  io_mem_resp_bits_typ,
  output logic [63:0] io_mem_resp_bits_data,
  output logic [63:0] io_mem_resp_bits_data_word_bypass,
  output logic [63:0] io_mem_resp_bits_store_data,
  output logic        io_mem_resp_bits_has_data,
  output logic        io_mem_resp_bits_nack,
  output logic        io_mem_resp_bits_replay
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(MAX_INFLIGHT + 1);

  typedef struct packed {
    logic        valid;
    logic [39:0] addr;
    logic [9:0]  tag;
    logic [4:0]  cmd;
    logic [2:0]  typ;
    logic [63:0] data;
    logic [63:0] store_data;
    logic        nack;
  } resp_t;

  logic [63:0]   mem_q [DEPTH];
  resp_t         pipe_q [LATENCY];
  logic [CW-1:0] inflight_q;
  logic [CW-1:0] inflight_d;

  logic          req_accept;
  logic          req_nack;
  logic          req_is_load;
  logic          req_is_store;
  logic [AW-1:0] req_widx;
  logic [63:0]   rd_word;
  resp_t         req_ent;
  resp_t         resp_ent;
  logic          resp_fire;

  logic unused_inputs;
  assign unused_inputs = io_mem_req_bits_phys ^ io_mem_invalidate_lr;

  // Ready only looks at the registered count: a response leaving this cycle
  // frees its slot one cycle later.
  always_comb begin
    io_mem_req_ready = !reset && (inflight_q < CW'(MAX_INFLIGHT));
    req_accept       = io_mem_req_valid && io_mem_req_ready;
    req_widx         = io_mem_req_bits_addr[3 +: AW];
    req_nack         = (io_mem_req_bits_cmd > 5'd1)
                    || (io_mem_req_bits_addr[39:3] >= 37'(DEPTH));
    req_is_load      = (io_mem_req_bits_cmd == 5'd0) && !req_nack;
    req_is_store     = (io_mem_req_bits_cmd == 5'd1) && !req_nack;
    rd_word          = mem_q[req_widx];
  end

  always_comb begin
    req_ent = '0;
    if (req_accept) begin
      req_ent.valid      = 1'b1;
      req_ent.addr       = io_mem_req_bits_addr;
      req_ent.tag        = io_mem_req_bits_tag;
      req_ent.cmd        = io_mem_req_bits_cmd;
      req_ent.typ        = io_mem_req_bits_typ;
      req_ent.data       = req_is_load  ? rd_word : 64'd0;
      req_ent.store_data = req_is_store ? io_mem_req_bits_data : 64'd0;
      req_ent.nack       = req_nack;
    end
  end

  always_comb begin
    resp_fire  = pipe_q[LATENCY-1].valid;
    inflight_d = inflight_q;
    case ({req_accept, resp_fire})
      2'b10:   inflight_d = inflight_q + CW'(1);
      2'b01:   inflight_d = inflight_q - CW'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      inflight_q <= '0;
      for (int i = 0; i < LATENCY; i++) pipe_q[i] <= '0;
    end else begin
      inflight_q <= inflight_d;
      pipe_q[0]  <= req_ent;
      for (int i = 1; i < LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  // Scratchpad is deliberately not reset; accepted stores survive a reset.
  always_ff @(posedge clk) begin
    if (req_accept && req_is_store) mem_q[req_widx] <= io_mem_req_bits_data;
  end

  always_comb begin
    resp_ent = (resp_fire && !reset) ? pipe_q[LATENCY-1] : '0;
    io_mem_resp_valid                 = resp_ent.valid;
    io_mem_resp_bits_addr             = resp_ent.addr;
    io_mem_resp_bits_tag              = resp_ent.tag;
    io_mem_resp_bits_cmd              = resp_ent.cmd;
    io_mem_resp_bits_typ              = resp_ent.typ;
    io_mem_resp_bits_data             = resp_ent.data;
    io_mem_resp_bits_data_word_bypass = resp_ent.data;
    io_mem_resp_bits_store_data       = resp_ent.store_data;
    io_mem_resp_bits_has_data         = resp_ent.valid && (resp_ent.cmd == 5'd0) && !resp_ent.nack;
    io_mem_resp_bits_nack             = resp_ent.nack;
    io_mem_resp_bits_replay           = 1'b0;
  end

endmodule

// File: tb/tb_rocc_mem_responder.sv
// Directed bench for rocc_mem_responder at default parameters (DEPTH=256,
// LATENCY=4, MAX_INFLIGHT=2) with hand-computed expected responses.
module tb_rocc_mem_responder;

  logic        clk;
  logic        reset;
  logic        req_ready;
  logic        req_valid;
  logic [39:0] req_addr;
  logic [9:0]  req_tag;
  logic [4:0]  req_cmd;
  logic [2:0]  req_typ;
  logic        req_phys;
  logic [63:0] req_data;
  logic        inv_lr;
  logic        resp_valid;
  logic [39:0] resp_addr;
  logic [9:0]  resp_tag;
  logic [4:0]  resp_cmd;
  logic [2:0]  resp_typ;
  logic [63:0] resp_data;
  logic [63:0] resp_bypass;
  logic [63:0] resp_store_data;
  logic        resp_has_data;
  logic        resp_nack;
  logic        resp_replay;

  int errors = 0;
  int checks = 0;
  int resp_cnt = 0;
  int snap;

  rocc_mem_responder dut (
    .clk                               (clk),
    .reset                             (reset),
    .io_mem_req_ready                  (req_ready),
    .io_mem_req_valid                  (req_valid),
    .io_mem_req_bits_addr              (req_addr),
    .io_mem_req_bits_tag               (req_tag),
    .io_mem_req_bits_cmd               (req_cmd),
    .io_mem_req_bits_typ               (req_typ),
    .io_mem_req_bits_phys              (req_phys),
    .io_mem_req_bits_data              (req_data),
    .io_mem_invalidate_lr              (inv_lr),
    .io_mem_resp_valid                 (resp_valid),
    .io_mem_resp_bits_addr             (resp_addr),
    .io_mem_resp_bits_tag              (resp_tag),
    .io_mem_resp_bits_cmd              (resp_cmd),
    .io_mem_resp_bits_typ              (resp_typ),
    .io_mem_resp_bits_data             (resp_data),
    .io_mem_resp_bits_data_word_bypass (resp_bypass),
    .io_mem_resp_bits_store_data       (resp_store_data),
    .io_mem_resp_bits_has_data         (resp_has_data),
    .io_mem_resp_bits_nack             (resp_nack),
    .io_mem_resp_bits_replay           (resp_replay)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (resp_valid === 1'b1) resp_cnt++;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic v, input logic [4:0] cmd, input logic [39:0] addr,
                         input logic [9:0] tag, input logic [63:0] data);
    req_valid = v;
    req_cmd   = cmd;
    req_addr  = addr;
    req_tag   = tag;
    req_data  = data;
    req_typ   = 3'd3;
  endtask

  // Issues one request, then leaves the bench in the response cycle.
  task automatic single(input string name, input logic [4:0] cmd, input logic [39:0] addr,
                        input logic [9:0] tag, input logic [63:0] data);
    set_req(1'b1, cmd, addr, tag, data);
    #1;
    chk({name, "_ready"}, 64'(req_ready), 64'd1);
    cyc();
    set_req(1'b0, 5'd0, 40'd0, 10'd0, 64'd0);
    cyc();
    cyc();
    chk({name, "_not_early"}, 64'(resp_valid), 64'd0);
    cyc();
    chk({name, "_valid"}, 64'(resp_valid), 64'd1);
    chk({name, "_tag"}, 64'(resp_tag), 64'(tag));
    chk({name, "_addr"}, 64'(resp_addr), 64'(addr));
    chk({name, "_cmd"}, 64'(resp_cmd), 64'(cmd));
  endtask

  bit exp_rdy [11]  = '{1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 1};
  bit exp_rv  [11]  = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 1};
  int exp_tag [11]  = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 2, 3};
  bit drv_v   [11]  = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0};
  int drv_tag [11]  = '{0, 1, 2, 2, 2, 2, 3, 0, 0, 0, 0};

  initial begin
    reset    = 1'b1;
    req_phys = 1'b0;
    inv_lr   = 1'b0;
    set_req(1'b0, 5'd0, 40'd0, 10'd0, 64'd0);
    cyc(); cyc(); cyc();
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_tag", 64'(resp_tag), 64'd0);
    chk("rst_replay", 64'(resp_replay), 64'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_ready", 64'(req_ready), 64'd1);

    // Store then load at 0x18
    single("st18", 5'd1, 40'h18, 10'd5, 64'hDEAD_BEEF_0123_4567);
    chk("st18_has_data", 64'(resp_has_data), 64'd0);
    chk("st18_store_data", resp_store_data, 64'hDEAD_BEEF_0123_4567);
    chk("st18_data", resp_data, 64'd0);
    chk("st18_nack", 64'(resp_nack), 64'd0);
    cyc();
    chk("st18_one_cycle", 64'(resp_valid), 64'd0);
    chk("idle_fields_zero", resp_store_data, 64'd0);

    single("ld18", 5'd0, 40'h18, 10'd2, 64'd0);
    chk("ld18_has_data", 64'(resp_has_data), 64'd1);
    chk("ld18_data", resp_data, 64'hDEAD_BEEF_0123_4567);
    chk("ld18_bypass", resp_bypass, 64'hDEAD_BEEF_0123_4567);
    chk("ld18_store_data", resp_store_data, 64'd0);
    cyc();

    // Store then load same address on consecutive cycles
    set_req(1'b1, 5'd1, 40'h20, 10'd8, 64'h1111_2222_3333_4444);
    #1;
    chk("b2b_st_ready", 64'(req_ready), 64'd1);
    cyc();
    set_req(1'b1, 5'd0, 40'h20, 10'd9, 64'd0);
    #1;
    chk("b2b_ld_ready", 64'(req_ready), 64'd1);
    cyc();
    set_req(1'b0, 5'd0, 40'd0, 10'd0, 64'd0);
    cyc(); cyc();
    chk("b2b_st_valid", 64'(resp_valid), 64'd1);
    chk("b2b_st_tag", 64'(resp_tag), 64'd8);
    cyc();
    chk("b2b_ld_valid", 64'(resp_valid), 64'd1);
    chk("b2b_ld_tag", 64'(resp_tag), 64'd9);
    chk("b2b_ld_data", resp_data, 64'h1111_2222_3333_4444);
    cyc();

    // Held-valid backpressure: accepts at 0,1,5,6; responses at 4,5,9,10
    for (int c = 0; c < 11; c++) begin
      set_req(drv_v[c], 5'd0, 40'h18, 10'(drv_tag[c]), 64'd0);
      #1;
      chk($sformatf("bp_ready_c%0d", c), 64'(req_ready), 64'(exp_rdy[c]));
      chk($sformatf("bp_rvalid_c%0d", c), 64'(resp_valid), 64'(exp_rv[c]));
      if (exp_rv[c]) begin
        chk($sformatf("bp_tag_c%0d", c), 64'(resp_tag), 64'(exp_tag[c]));
        chk($sformatf("bp_data_c%0d", c), resp_data, 64'hDEAD_BEEF_0123_4567);
      end
      cyc();
    end
    cyc();

    // Out-of-range load and illegal command
    single("oor", 5'd0, 40'h800, 10'd7, 64'd0);
    chk("oor_nack", 64'(resp_nack), 64'd1);
    chk("oor_has_data", 64'(resp_has_data), 64'd0);
    chk("oor_data", resp_data, 64'd0);
    cyc();
    single("st0", 5'd1, 40'h0, 10'd3, 64'hA5A5_5A5A_0F0F_F0F0);
    chk("st0_nack", 64'(resp_nack), 64'd0);
    cyc();
    single("badcmd", 5'd5, 40'h0, 10'd4, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("badcmd_nack", 64'(resp_nack), 64'd1);
    chk("badcmd_has_data", 64'(resp_has_data), 64'd0);
    cyc();
    single("ld0", 5'd0, 40'h0, 10'd6, 64'd0);
    chk("ld0_nack", 64'(resp_nack), 64'd0);
    chk("ld0_data", resp_data, 64'hA5A5_5A5A_0F0F_F0F0);
    cyc();

    // Last word; byte offset bits ignored
    single("st_last", 5'd1, 40'h7F8, 10'd10, 64'h0123_4567_89AB_CDEF);
    chk("st_last_nack", 64'(resp_nack), 64'd0);
    cyc();
    single("ld_last", 5'd0, 40'h7FF, 10'd11, 64'd0);
    chk("ld_last_nack", 64'(resp_nack), 64'd0);
    chk("ld_last_data", resp_data, 64'h0123_4567_89AB_CDEF);
    cyc();

    // Reset mid-flight drops both pending responses
    set_req(1'b1, 5'd0, 40'h18, 10'd1, 64'd0);
    #1;
    chk("rf_acc0_ready", 64'(req_ready), 64'd1);
    cyc();
    set_req(1'b1, 5'd0, 40'h18, 10'd2, 64'd0);
    #1;
    chk("rf_acc1_ready", 64'(req_ready), 64'd1);
    cyc();
    set_req(1'b0, 5'd0, 40'd0, 10'd0, 64'd0);
    reset = 1'b1;
    #1;
    snap = resp_cnt;
    chk("rf_ready_in_reset", 64'(req_ready), 64'd0);
    chk("rf_rvalid_in_reset", 64'(resp_valid), 64'd0);
    cyc();
    reset = 1'b0;
    #1;
    chk("rf_ready_after", 64'(req_ready), 64'd1);
    for (int i = 0; i < 6; i++) cyc();
    chk("rf_no_resp", 64'(resp_cnt - snap), 64'd0);
    single("rf_ld", 5'd0, 40'h18, 10'h3FF, 64'd0);
    chk("rf_ld_data", resp_data, 64'hDEAD_BEEF_0123_4567);
    chk("rf_ld_has_data", 64'(resp_has_data), 64'd1);
    cyc();
    chk("final_replay", 64'(resp_replay), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rocc_mem_responder.md
# rocc_mem_responder

Fixed-latency memory responder for the RoCC accelerator's L1 memory port (io_mem_req / io_mem_resp). It accepts load and store requests from an accelerator, services them from an internal 64-bit-word scratchpad, and returns tagged responses a fixed number of cycles later. It stands in for the HellaCache in accelerator unit benches and standalone FPGA bring-up, and exercises the accelerator's per-tag busy tracking and request backpressure.

## Interface
Parameters:
- DEPTH, 256: scratchpad size in 64-bit words; power of two.
- LATENCY, 4: cycles from request accept to response; ≥1.
- MAX_INFLIGHT, 2: maximum accepted-but-unanswered requests; 1..LATENCY.

Ports:
- clk  in  1  sole clock; everything is on the rising edge.
- reset  in  1  synchronous, active-high.
- io_mem_req_ready  out  1  request accepted this cycle if valid.
- io_mem_req_valid  in  1  request present.
- io_mem_req_bits_addr  in  40  byte address; word index = addr[3+log2(DEPTH)-1:3].
- io_mem_req_bits_tag  in  10  echoed in the response.
- io_mem_req_bits_cmd  in  5  0 = load (M_XRD), 1 = store (M_XWR).
- io_mem_req_bits_typ  in  3  echoed; always a full 64-bit access.
- io_mem_req_bits_phys  in  1  ignored.
- io_mem_req_bits_data  in  64  store data.
- io_mem_invalidate_lr  in  1  ignored.
- io_mem_resp_valid  out  1  response present; single-cycle pulse, no backpressure.
- io_mem_resp_bits_addr / _tag / _cmd / _typ  out  40/10/5/3  echoed request fields.
- io_mem_resp_bits_data  out  64  load data.
- io_mem_resp_bits_data_word_bypass  out  64  same as data.
- io_mem_resp_bits_store_data  out  64  store data of a store response, else 0.
- io_mem_resp_bits_has_data  out  1  1 for a non-nacked load.
- io_mem_resp_bits_nack  out  1  request rejected; no memory effect.
- io_mem_resp_bits_replay  out  1  constant 0.

## Operation
- Accept = io_mem_req_valid & io_mem_req_ready. At most one accept per cycle.
- io_mem_req_ready = !reset & (inflight < MAX_INFLIGHT). Computed from the registered count only; a response leaving in the same cycle does not free a slot until the next cycle.
- inflight counter: +1 on accept, −1 on response, unchanged when both occur. Width is clog2(MAX_INFLIGHT+1). Never exceeds MAX_INFLIGHT and never underflows.
- Nack when cmd ∉ {0,1} or addr[39:3] ≥ DEPTH, i.e. out of range (addr[2:0] ignored). A nacked request gets a response with nack=1, has_data=0, data=0, and makes no memory write.
- Store: writes the memory word in the accept cycle. Its response has has_data=0, data=0, store_data = request data.
- Load: reads the memory word in the accept cycle, so it sees every store accepted in an earlier cycle. The data travels with the request down the pipeline. Response has has_data=1, data = data_word_bypass = the read word.
- Pipeline: LATENCY-stage shift register of {valid, addr, tag, cmd, typ, data, store_data, nack}. Responses are strictly in accept order.
- Response field values are 0 when io_mem_resp_valid=0.
- Memory contents are not reset (X in simulation). Benches write before they read.

## Timing
- Accept in cycle N → io_mem_resp_valid high in cycle N+LATENCY, for exactly one cycle.
- Back-to-back throughput is MAX_INFLIGHT accepts per LATENCY+1 cycles when MAX_INFLIGHT < LATENCY+1; otherwise 1 per cycle.
- Reset (any cycle, including mid-operation):
  - all pipeline valids and inflight cleared the next cycle;
  - in-flight responses are dropped and never emitted;
  - stores already accepted remain in memory.
- Values during and immediately after reset: io_mem_req_ready=0 while reset is high; io_mem_resp_valid=0 and all resp fields 0; replay=0 always. First accept is possible in the first cycle after reset deasserts.
- Inflight at MAX_INFLIGHT with a response in the same cycle: ready stays 0 that cycle and is 1 the next.

## Test plan
- Store addr 0x18, data 0xDEAD_BEEF_0123_4567, tag 5 → resp 4 cycles later: tag 5, cmd 1, has_data 0, store_data 0xDEAD_BEEF_0123_4567. Load addr 0x18, tag 2 → resp: tag 2, has_data 1, data 0xDEAD_BEEF_0123_4567.
- Store then load to the same address in consecutive cycles (MAX_INFLIGHT=2) → load returns the new value; responses one cycle apart, in order.
- Hold valid with 4 loads (tags 0..3), defaults → ready falls after 2 accepts. Accepts occur at cycles 0, 1, 5, 6; responses at cycles 4, 5, 9, 10.
- Load addr 0x800 (DEPTH=256), tag 7 → nack 1, has_data 0, data 0. Cmd 5 store to 0x0 → nack 1; a later load of 0x0 returns the prior contents.
- Accept 2 loads, assert reset for 1 cycle at cycle 2 → no response is ever emitted. Ready is 0 during reset and 1 the next cycle. A new load is answered normally.
- Randomized 10k ops against a reference array model: check tag/addr/data match, ordering, latency, and inflight ≤ MAX_INFLIGHT.
